// File: rtl/mono_colour_proc_if.sv
// Custom-palette write port of the monochrome colouriser.
// The master drives a one-cycle write strobe, and the slave reports when a write is pending.
interface mono_colour_proc_if #(
    parameter int unsigned IN_W = 2
);
    logic            cust_wr;
    logic [IN_W-1:0] cust_addr;
    logic [23:0]     cust_data;
    logic            cust_busy;

    modport master (output cust_wr, cust_addr, cust_data, input cust_busy);
    modport slave  (input cust_wr, cust_addr, cust_data, output cust_busy);
endinterface

// File: rtl/mono_colour_proc.sv
// Three-stage monochrome colouriser: RGB -> luma level -> tint palette lookup, with
// sync/blank delayed alongside, and tint/custom-palette updates deferred to vertical blank.
module mono_colour_proc #(
    parameter int unsigned IN_W        = 2,
    parameter bit          USE_LUMA    = 1'b1,
    parameter bit          BLANK_BLACK = 1'b1
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             ce_pix,
    input  logic [IN_W-1:0]  r_in,
    input  logic [IN_W-1:0]  g_in,
    input  logic [IN_W-1:0]  b_in,
    input  logic             hs_in,
    input  logic             vs_in,
    input  logic             hblank_in,
    input  logic             vblank_in,
    input  logic [1:0]       tint_sel,
    mono_colour_proc_if.slave cust,
    output logic [1:0]       tint_active,
    output logic [7:0]       r_out,
    output logic [7:0]       g_out,
    output logic [7:0]       b_out,
    output logic             hs_out,
    output logic             vs_out,
    output logic             hblank_out,
    output logic             vblank_out
);
    localparam int unsigned LEVELS = 1 << IN_W;
    localparam int unsigned SUM_W  = IN_W + 5;

    typedef logic [LEVELS-1:0][23:0] pal_t;

    // Rounded k/(LEVELS-1) fraction of one full-scale channel
    function automatic logic [7:0] scale(input int unsigned full, input int unsigned k);
        return 8'((full * k * 2 + (LEVELS - 1)) / (2 * (LEVELS - 1)));
    endfunction

    function automatic pal_t ramp(input logic [23:0] f);
        pal_t p;
        for (int unsigned k = 0; k < LEVELS; k++)
            p[IN_W'(k)] = {scale(32'(f[23:16]), k), scale(32'(f[15:8]), k), scale(32'(f[7:0]), k)};
        return p;
    endfunction

    localparam pal_t PAL_WHITE = ramp(24'hFFFFFF);
    localparam pal_t PAL_GREEN = ramp(24'h00F600);
    localparam pal_t PAL_AMBER = ramp(24'h5CF600);

    logic [IN_W-1:0] r1, g1, b1;
    logic            hs1, vs1, hb1, vb1;
    logic [IN_W-1:0] level2;
    logic            hs2, vs2, hb2, vb2;
    pal_t            cust_pal;
    logic            busy;
    logic [IN_W-1:0] pend_addr;
    logic [23:0]     pend_data;
    logic [IN_W-1:0] level_c;
    logic [23:0]     lookup_c;

    generate
        if (USE_LUMA) begin : g_luma
            logic [SUM_W-1:0] sum_c;
            always_comb begin
                sum_c   = SUM_W'(5) * SUM_W'(r1) + SUM_W'(9) * SUM_W'(g1) + SUM_W'(2) * SUM_W'(b1);
                level_c = IN_W'(sum_c >> 4);
            end
        end else begin : g_green
            assign level_c = g1;
        end
    endgenerate

    always_comb begin
        lookup_c = PAL_WHITE[level2];
        case (tint_active)
            2'd1:    lookup_c = PAL_GREEN[level2];
            2'd2:    lookup_c = PAL_AMBER[level2];
            2'd3:    lookup_c = cust_pal[level2];
            default: lookup_c = PAL_WHITE[level2];
        endcase
    end

    assign cust.cust_busy = busy;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            {r1, g1, b1}                      <= '0;
            {hs1, vs1, hb1, vb1}              <= '0;
            level2                            <= '0;
            {hs2, vs2, hb2, vb2}              <= '0;
            {r_out, g_out, b_out}             <= '0;
            {hs_out, vs_out, hblank_out, vblank_out} <= '0;
            tint_active                       <= 2'd0;
            cust_pal                          <= PAL_WHITE;
            busy                              <= 1'b0;
            pend_addr                         <= '0;
            pend_data                         <= '0;
        end else begin
            if (ce_pix) begin
                {r1, g1, b1}          <= {r_in, g_in, b_in};
                {hs1, vs1, hb1, vb1}  <= {hs_in, vs_in, hblank_in, vblank_in};
                level2                <= level_c;
                {hs2, vs2, hb2, vb2}  <= {hs1, vs1, hb1, vb1};
                {r_out, g_out, b_out} <= (BLANK_BLACK && (hb2 || vb2)) ? 24'h0 : lookup_c;
                {hs_out, vs_out, hblank_out, vblank_out} <= {hs2, vs2, hb2, vb2};
                // S2 still holds the previous S1 vblank, so this is the S1 rising edge
                if (vb1 && !vb2)
                    tint_active <= tint_sel;
            end
            // Custom entries are only allowed to change while the custom tint is not on screen
            if (busy) begin
                if (vb1) begin
                    cust_pal[pend_addr] <= pend_data;
                    busy                <= 1'b0;
                end
            end else if (cust.cust_wr) begin
                if (tint_active != 2'd3 || vb1) begin
                    cust_pal[cust.cust_addr] <= cust.cust_data;
                end else begin
                    busy      <= 1'b1;
                    pend_addr <= cust.cust_addr;
                    pend_data <= cust.cust_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_mono_colour_proc.sv
// Bench for mono_colour_proc: directed table and sequences, then random traffic
// compared against a frame-level reference model every clock.
module tb_mono_colour_proc;
    localparam int unsigned IN_W   = 2;
    localparam int unsigned LEVELS = 1 << IN_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            n_reset, ce_pix;
    logic [IN_W-1:0] r_in, g_in, b_in;
    logic            hs_in, vs_in, hblank_in, vblank_in;
    logic [1:0]      tint_sel;
    logic [1:0]      tint_active, tint_nb;
    logic [7:0]      r_out, g_out, b_out, r_nb, g_nb, b_nb;
    logic            hs_out, vs_out, hblank_out, vblank_out;
    logic            hs_nb, vs_nb, hb_nb, vb_nb;

    mono_colour_proc_if #(.IN_W(IN_W)) cif ();
    mono_colour_proc_if #(.IN_W(IN_W)) cif_nb ();

    mono_colour_proc #(.IN_W(IN_W), .USE_LUMA(1'b1), .BLANK_BLACK(1'b1)) dut (
        .clk(clk), .n_reset(n_reset), .ce_pix(ce_pix),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .hs_in(hs_in), .vs_in(vs_in), .hblank_in(hblank_in), .vblank_in(vblank_in),
        .tint_sel(tint_sel), .cust(cif.slave), .tint_active(tint_active),
        .r_out(r_out), .g_out(g_out), .b_out(b_out),
        .hs_out(hs_out), .vs_out(vs_out), .hblank_out(hblank_out), .vblank_out(vblank_out)
    );

    mono_colour_proc #(.IN_W(IN_W), .USE_LUMA(1'b1), .BLANK_BLACK(1'b0)) dut_nb (
        .clk(clk), .n_reset(n_reset), .ce_pix(ce_pix),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .hs_in(hs_in), .vs_in(vs_in), .hblank_in(hblank_in), .vblank_in(vblank_in),
        .tint_sel(tint_sel), .cust(cif_nb.slave), .tint_active(tint_nb),
        .r_out(r_nb), .g_out(g_nb), .b_out(b_nb),
        .hs_out(hs_nb), .vs_out(vs_nb), .hblank_out(hb_nb), .vblank_out(vb_nb)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference model: pixels recorded per pixel pulse, palettes computed from the colour rules
    typedef struct { int r; int g; int b; bit hs; bit vs; bit hb; bit vb; } pix_t;
    pix_t hist [2];
    int   m_cust [LEVELS];
    int   m_tint, m_paddr, m_pdata, m_rgb;
    bit   m_busy, m_hs, m_vs, m_hb, m_vb;

    typedef struct { int r; int g; int b; int exp; } vec_t;
    vec_t vecs [8];

    function automatic int preset(input int full, input int k);
        int res = 0;
        for (int sh = 0; sh < 24; sh += 8) begin
            int c = (full >> sh) & 255;
            res |= int'(real'(c) * real'(k) / real'(LEVELS - 1)) << sh;
        end
        return res;
    endfunction

    function automatic int palette(input int tint, input int level);
        case (tint)
            0:       return preset(32'hFFFFFF, level);
            1:       return preset(32'h00F600, level);
            2:       return preset(32'h5CF600, level);
            default: return m_cust[level];
        endcase
    endfunction

    function automatic int luma(input pix_t p);
        return (5 * p.r + 9 * p.g + 2 * p.b) / 16;
    endfunction

    task automatic model_step();
        bit s1_vb;
        if (!n_reset) begin
            for (int i = 0; i < 2; i++) hist[i] = '{0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
            for (int k = 0; k < int'(LEVELS); k++) m_cust[k] = preset(32'hFFFFFF, k);
            m_tint = 0; m_busy = 1'b0; m_rgb = 0;
            {m_hs, m_vs, m_hb, m_vb} = 4'b0;
        end else begin
            s1_vb = hist[0].vb;
            if (ce_pix) begin
                m_rgb = (hist[1].hb || hist[1].vb) ? 0 : palette(m_tint, luma(hist[1]));
                {m_hs, m_vs, m_hb, m_vb} = {hist[1].hs, hist[1].vs, hist[1].hb, hist[1].vb};
            end
            if (m_busy) begin
                if (s1_vb) begin m_cust[m_paddr] = m_pdata; m_busy = 1'b0; end
            end else if (cif.cust_wr) begin
                if (m_tint != 3 || s1_vb) m_cust[int'(cif.cust_addr)] = int'(cif.cust_data);
                else begin m_busy = 1'b1; m_paddr = int'(cif.cust_addr); m_pdata = int'(cif.cust_data); end
            end
            if (ce_pix) begin
                if (hist[0].vb && !hist[1].vb) m_tint = int'(tint_sel);
                hist[1] = hist[0];
                hist[0] = '{int'(r_in), int'(g_in), int'(b_in), hs_in, vs_in, hblank_in, vblank_in};
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %06h expected %06h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        if (chk_en) begin
            check("model_rgb", 32'({r_out, g_out, b_out}), m_rgb);
            check("model_timing", 32'({hs_out, vs_out, hblank_out, vblank_out}), 32'({m_hs, m_vs, m_hb, m_vb}));
            check("model_busy", 32'(cif.cust_busy), 32'(m_busy));
            check("model_tint", 32'(tint_active), m_tint);
        end
    endtask

    task automatic pulse();
        ce_pix = 1'b1; cyc();
        ce_pix = 1'b0; cyc(); cyc(); cyc();
    endtask

    task automatic pulses(input int n);
        repeat (n) pulse();
    endtask

    task automatic set_rgb(input int r, input int g, input int b);
        r_in = IN_W'(r); g_in = IN_W'(g); b_in = IN_W'(b);
    endtask

    task automatic cust_write(input int addr, input int data);
        cif.cust_wr = 1'b1; cif.cust_addr = IN_W'(addr); cif.cust_data = 24'(data);
        cyc();
        cif.cust_wr = 1'b0;
    endtask

    // Vblank for four pulses then three visible pulses, so the tint request is taken up
    task automatic frame_turn();
        vblank_in = 1'b1; pulses(4);
        vblank_in = 1'b0; pulses(3);
    endtask

    function automatic int rgb();
        return 32'({r_out, g_out, b_out});
    endfunction

    initial begin
        vecs[0] = '{0, 3, 0, 32'h555555};
        vecs[1] = '{3, 0, 0, 32'h000000};
        vecs[2] = '{3, 3, 0, 32'hAAAAAA};
        vecs[3] = '{3, 3, 3, 32'hFFFFFF};
        vecs[4] = '{0, 0, 3, 32'h000000};
        vecs[5] = '{1, 1, 1, 32'h555555};
        vecs[6] = '{2, 2, 2, 32'hAAAAAA};
        vecs[7] = '{0, 2, 3, 32'h555555};

        n_reset = 1'b0; ce_pix = 1'b0; set_rgb(0, 0, 0);
        {hs_in, vs_in, hblank_in, vblank_in} = 4'b0;
        tint_sel = 2'd0;
        cif.cust_wr = 1'b0; cif.cust_addr = '0; cif.cust_data = '0;
        cif_nb.cust_wr = 1'b0; cif_nb.cust_addr = '0; cif_nb.cust_data = '0;
        cyc();
        chk_en = 1'b1;
        cyc();
        check("reset_rgb", rgb(), 0);
        check("reset_tint", 32'(tint_active), 0);
        check("reset_busy", 32'(cif.cust_busy), 0);

        // Latency: exactly three pixel pulses
        n_reset = 1'b1; set_rgb(3, 3, 3); hs_in = 1'b1;
        pulses(2);
        check("lat2_rgb", rgb(), 0);
        check("lat2_hs", 32'(hs_out), 0);
        pulse();
        check("lat3_rgb", rgb(), 32'hFFFFFF);
        check("lat3_hs", 32'(hs_out), 1);
        hs_in = 1'b0; pulses(2);
        check("hs_hold", 32'(hs_out), 1);
        pulse();
        check("hs_fall", 32'(hs_out), 0);

        foreach (vecs[i]) begin
            set_rgb(vecs[i].r, vecs[i].g, vecs[i].b);
            pulses(3);
            check($sformatf("luma_vec%0d", i), rgb(), vecs[i].exp);
        end

        set_rgb(3, 3, 3); hblank_in = 1'b1; pulses(3);
        check("blank_black", rgb(), 0);
        check("blank_off_param", 32'({r_nb, g_nb, b_nb}), 32'hFFFFFF);
        check("blank_flag", 32'(hblank_out), 1);
        hblank_in = 1'b0; pulses(3);
        check("unblank", rgb(), 32'hFFFFFF);

        // Tint request is deferred to the next vblank rise
        tint_sel = 2'd2; pulses(3);
        check("tint_deferred", 32'(tint_active), 0);
        check("tint_deferred_rgb", rgb(), 32'hFFFFFF);
        frame_turn();
        check("tint_amber", 32'(tint_active), 2);
        check("amber_l3", rgb(), 32'h5CF600);
        set_rgb(0, 3, 0); pulses(3);
        check("amber_l1", rgb(), 32'h1F5200);
        tint_sel = 2'd1; set_rgb(3, 3, 3); pulses(3);
        check("tint_still_amber", 32'(tint_active), 2);
        frame_turn();
        check("green_l3", rgb(), 32'h00F600);

        // Custom palette writes while the custom tint is visible
        tint_sel = 2'd3; frame_turn();
        check("tint_custom", 32'(tint_active), 3);
        check("custom_white_l3", rgb(), 32'hFFFFFF);
        cust_write(3, 32'h123456);
        check("busy_set", 32'(cif.cust_busy), 1);
        cust_write(3, 32'hFFFFFF);
        check("busy_hold", 32'(cif.cust_busy), 1);
        pulses(3);
        check("pending_invisible", rgb(), 32'hFFFFFF);
        vblank_in = 1'b1; pulse();
        check("busy_clear", 32'(cif.cust_busy), 0);
        cust_write(2, 32'hABCDEF);
        check("vblank_write_busy", 32'(cif.cust_busy), 0);
        pulses(3);
        vblank_in = 1'b0; pulses(3);
        check("custom_l3", rgb(), 32'h123456);
        set_rgb(3, 3, 0); pulses(3);
        check("custom_l2", rgb(), 32'hABCDEF);

        // Reset with a write pending
        tint_sel = 2'd2;
        cust_write(3, 32'h00FF00);
        check("busy_before_reset", 32'(cif.cust_busy), 1);
        n_reset = 1'b0; cyc(); cyc();
        n_reset = 1'b1;
        check("rst_busy", 32'(cif.cust_busy), 0);
        check("rst_tint", 32'(tint_active), 0);
        check("rst_rgb", rgb(), 0);
        set_rgb(3, 3, 3); tint_sel = 2'd3; frame_turn();
        check("rst_tint_custom", 32'(tint_active), 3);
        check("rst_custom_l3", rgb(), 32'hFFFFFF);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            ce_pix = ($urandom_range(0, 2) == 0);
            set_rgb(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            hs_in = ($urandom_range(0, 7) == 0);
            vs_in = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) hblank_in = ~hblank_in;
            if ($urandom_range(0, 15) == 0) vblank_in = ~vblank_in;
            if ($urandom_range(0, 31) == 0) tint_sel = 2'($urandom);
            cif.cust_wr   = ($urandom_range(0, 9) == 0);
            cif.cust_addr = IN_W'($urandom);
            cif.cust_data = 24'($urandom);
            n_reset = ($urandom_range(0, 999) != 0);
            cyc();
        end
        n_reset = 1'b1; cif.cust_wr = 1'b0; ce_pix = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
